mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the core_lapido pipeline. It consumes the execute-stage result bundle: ALU result and flags, memory address and data, absolute jump target, destination register, and propagated control.
- Holds the EX/MEM pipeline register and the architectural flag register.
- Performs data-memory loads and stores over a req/ack handshake with a timeout, and resolves branches and jumps.
- Drives the MEM/WB register and stalls upstream while an access is outstanding.

Parameters:
- PC_WIDTH, `PC_WIDTH, width of the next-PC field.
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for dmem_ack before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  EX bundle is valid this cycle
- in_mem_write_enable  in  1  store
- in_fl_write_enable  in  1  update flag register
- in_sel_jt_jf  in  1  branch polarity: 1 = take if flag set, 0 = take if flag clear
- in_is_branch  in  1  conditional branch
- in_is_jump  in  1  unconditional jump
- in_wb_res_mux  in  2  writeback source; `WB_MEM marks a load
- in_reg_write_enable  in  1  register write
- in_next_pc  in  PC_WIDTH  return PC
- in_abs_addr  in  32  branch/jump target
- in_mem_addr  in  32  data address
- in_mem_data  in  32  store data
- in_alu_out  in  32  ALU result
- in_alu_flags  in  6  ALU flags
- in_flag_addr  in  5  flag select; bits [2:0] used, values 6 and 7 read as 0
- in_reg_dst  in  5  destination register
- stall  out  1  hold upstream stages
- branch_taken  out  1  redirect fetch
- branch_target  out  32  redirect address
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  memory address
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data
- dmem_ack  in  1  access complete
- mem_error  out  1  one-cycle timeout pulse
- flags  out  6  flag register
- wb_valid, wb_reg_write_enable, wb_res_mux[2], wb_reg_dst[5], wb_alu_out[32], wb_mem_rdata[32], wb_next_pc[PC_WIDTH]  out  MEM/WB register

Behaviour:
- Reset: asynchronous, active-high. All registers clear: state IDLE, stall=0, dmem_req=0, dmem_we=0, flags=0, mem_error=0, all wb_* outputs = 0.
- EX/MEM capture:
  - The register loads on every edge where stall=0.
  - Its valid bit becomes in_valid & ~branch_taken, so the wrong-path instruction arriving on a taken-branch edge is squashed.
- Flag register:
  - On a capture edge with in_valid & in_fl_write_enable, flags <= in_alu_flags.
  - The next captured instruction sees the updated value; no bypass is needed.
- Branch resolution (combinational from the EX/MEM register):
  - cond = flags[flag_addr[2:0]] when flag_addr[2:0] < 6, else 0.
  - branch_taken = valid & (is_jump | (is_branch & (cond == sel_jt_jf))).
  - branch_target = captured abs_addr.
  - Neither output depends on memory access completion.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If the captured instruction is valid and is a store or load (wb_res_mux==`WB_MEM), go to ACCESS.
  - Otherwise the next edge writes the MEM/WB register: wb_valid=valid, wb_mem_rdata=0. Latency is one cycle.
- ACCESS:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata come from the captured instruction and stay constant while req is high.
  - stall = ~dmem_ack & (cnt != TIMEOUT-1).
  - cnt clears on entry and increments each cycle.
  - When dmem_ack=1: capture dmem_rdata (stores write 0), write MEM/WB, return to IDLE. stall is already 0 in this cycle, so a new bundle is captured on the same edge.
  - Timeout (cnt == TIMEOUT-1 without ack): abort. wb_mem_rdata=0 and wb_reg_write_enable=0 (the instruction is killed). mem_error pulses for one cycle. Go to IDLE.
- DONE is reserved. It goes to IDLE unconditionally and is unreachable.
- Simultaneous ack and timeout: ack wins; no error.
- Reset during ACCESS: dmem_req drops immediately and the outstanding instruction is lost.
- wb_valid=0 on any cycle where no instruction completes.

Decomposition:
- lapido_defs.v gains:
  - `WB_ALU=2'd0, `WB_MEM=2'd1, `WB_PC=2'd2
  - MEM FSM state encodings
  - `FLAG_COUNT=6
- One sub-module, mem_access_fsm, holds the state, the timeout counter, dmem_req/we, stall and mem_error.
- Pipeline registers, flag register and branch logic stay in mem_stage.

Test Plan:
- ALU op with in_alu_out=0x1234, reg_dst=5, no memory access -> next cycle wb_valid=1, wb_alu_out=0x1234, wb_reg_dst=5, stall never asserted.
- Load from addr 0x40 with ack after 3 cycles and rdata=0xDEADBEEF -> dmem_req high for 3 cycles, stall=1 for the first 2 of them, wb_mem_rdata=0xDEADBEEF, dmem_we=0.
- Store of 0xA5A5A5A5 to 0x80 with same-cycle ack -> dmem_we=1, stall=0 throughout, the following instruction is captured on the ack edge.
- ALU op with fl_write_enable, flags=6'b000001, followed by a branch with flag_addr=0, sel_jt_jf=1, abs_addr=0x100 -> branch_taken=1, branch_target=0x100; the instruction arriving on that edge is squashed (wb_valid=0 for it).
- Load with no ack, TIMEOUT=16 -> stall held for 15 cycles, mem_error pulses once, wb_reg_write_enable=0, then IDLE.
- rst asserted mid-ACCESS -> dmem_req, stall and flags drop to 0 asynchronously; after release the stage accepts a new instruction normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the core_lapido memory stage: writeback source selects,
// memory FSM states and the flag register width.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int FLAG_COUNT = 6;

  function automatic logic is_mem_op(input logic mem_we, input logic [1:0] res_mux);
    return mem_we | (res_mux == WB_MEM);
  endfunction

endpackage

// File: rtl/mem_stage_access_fsm.sv
// Data-memory access sequencer: request/ack handshake with a bounded wait,
// upstream stall generation and a one-cycle timeout error pulse.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       access_we,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       stall,
  output logic       mem_error,
  output logic       ack_done,
  output logic       timeout,
  output logic [1:0] state
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;
  logic          in_access;
  logic          cnt_last;

  // Handshake: dmem_req is held high with constant we/addr/wdata for every
  // ACCESS cycle; the access completes in the cycle where dmem_ack is high
  // (same-cycle ack allowed). An ack on the last allowed cycle beats timeout.
  assign in_access = (state == ST_ACCESS);
  assign cnt_last  = (cnt == CW'(TIMEOUT - 1));
  assign ack_done  = in_access & dmem_ack;
  assign timeout   = in_access & ~dmem_ack & cnt_last;
  assign stall     = in_access & ~dmem_ack & ~cnt_last;
  assign dmem_req  = in_access;
  assign dmem_we   = in_access & access_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_error <= 1'b0;
    end else begin
      mem_error <= timeout;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACCESS;
            cnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (!stall) begin
            state <= start ? ST_ACCESS : ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// core_lapido memory stage: EX/MEM register, flag register, branch resolution,
// data-memory access via mem_access_fsm and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mem_write_enable,
  input  logic                  in_fl_write_enable,
  input  logic                  in_sel_jt_jf,
  input  logic                  in_is_branch,
  input  logic                  in_is_jump,
  input  logic [1:0]            in_wb_res_mux,
  input  logic                  in_reg_write_enable,
  input  logic [PC_WIDTH-1:0]   in_next_pc,
  input  logic [31:0]           in_abs_addr,
  input  logic [31:0]           in_mem_addr,
  input  logic [31:0]           in_mem_data,
  input  logic [31:0]           in_alu_out,
  input  logic [FLAG_COUNT-1:0] in_alu_flags,
  input  logic [4:0]            in_flag_addr,
  input  logic [4:0]            in_reg_dst,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [31:0]           branch_target,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  mem_error,
  output logic [FLAG_COUNT-1:0] flags,
  output logic                  wb_valid,
  output logic                  wb_reg_write_enable,
  output logic [1:0]            wb_res_mux,
  output logic [4:0]            wb_reg_dst,
  output logic [31:0]           wb_alu_out,
  output logic [31:0]           wb_mem_rdata,
  output logic [PC_WIDTH-1:0]   wb_next_pc
);

  logic                ex_valid, ex_mem_we, ex_sel_jt_jf, ex_is_branch, ex_is_jump, ex_reg_we;
  logic [1:0]          ex_res_mux;
  logic [PC_WIDTH-1:0] ex_next_pc;
  logic [31:0]         ex_abs_addr, ex_mem_addr, ex_mem_data, ex_alu_out;
  logic [2:0]          ex_flag_addr;
  logic [4:0]          ex_reg_dst;

  logic       capture, start, cond, ack_done, timeout;
  logic [1:0] fsm_state;
  logic [7:0] flag_vec;
  logic       unused_flag_hi;

  assign unused_flag_hi = ^in_flag_addr[4:3];
  assign capture        = ~stall;

  // Flag selects 6 and 7 land on the zero padding and read as 0.
  assign flag_vec      = {{(8 - FLAG_COUNT){1'b0}}, flags};
  assign cond          = flag_vec[ex_flag_addr];
  assign branch_taken  = ex_valid & (ex_is_jump | (ex_is_branch & (cond == ex_sel_jt_jf)));
  assign branch_target = ex_abs_addr;

  // The access starts on the capture edge itself, so the EX/MEM register
  // already holds the memory instruction throughout ACCESS.
  assign start = capture & in_valid & ~branch_taken
               & is_mem_op(in_mem_write_enable, in_wb_res_mux);

  assign dmem_addr  = ex_mem_addr;
  assign dmem_wdata = ex_mem_data;

  mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .access_we (ex_mem_we),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .stall     (stall),
    .mem_error (mem_error),
    .ack_done  (ack_done),
    .timeout   (timeout),
    .state     (fsm_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_mem_we    <= 1'b0;
      ex_sel_jt_jf <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_is_jump   <= 1'b0;
      ex_reg_we    <= 1'b0;
      ex_res_mux   <= WB_ALU;
      ex_next_pc   <= '0;
      ex_abs_addr  <= '0;
      ex_mem_addr  <= '0;
      ex_mem_data  <= '0;
      ex_alu_out   <= '0;
      ex_flag_addr <= '0;
      ex_reg_dst   <= '0;
      flags        <= '0;
    end else if (capture) begin
      ex_valid     <= in_valid & ~branch_taken;
      ex_mem_we    <= in_mem_write_enable;
      ex_sel_jt_jf <= in_sel_jt_jf;
      ex_is_branch <= in_is_branch;
      ex_is_jump   <= in_is_jump;
      ex_reg_we    <= in_reg_write_enable;
      ex_res_mux   <= in_wb_res_mux;
      ex_next_pc   <= in_next_pc;
      ex_abs_addr  <= in_abs_addr;
      ex_mem_addr  <= in_mem_addr;
      ex_mem_data  <= in_mem_data;
      ex_alu_out   <= in_alu_out;
      ex_flag_addr <= in_flag_addr[2:0];
      ex_reg_dst   <= in_reg_dst;
      // A squashed wrong-path instruction must not disturb the flags either.
      if (in_valid & in_fl_write_enable & ~branch_taken) flags <= in_alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid            <= 1'b0;
      wb_reg_write_enable <= 1'b0;
      wb_res_mux          <= WB_ALU;
      wb_reg_dst          <= '0;
      wb_alu_out          <= '0;
      wb_mem_rdata        <= '0;
      wb_next_pc          <= '0;
    end else if (fsm_state == ST_ACCESS) begin
      if (ack_done | timeout) begin
        wb_valid            <= 1'b1;
        wb_reg_write_enable <= ex_reg_we & ack_done;
        wb_res_mux          <= ex_res_mux;
        wb_reg_dst          <= ex_reg_dst;
        wb_alu_out          <= ex_alu_out;
        wb_mem_rdata        <= (ack_done & ~ex_mem_we) ? dmem_rdata : 32'd0;
        wb_next_pc          <= ex_next_pc;
      end else begin
        wb_valid <= 1'b0;
      end
    end else begin
      wb_valid            <= ex_valid & (fsm_state == ST_IDLE);
      wb_reg_write_enable <= ex_reg_we;
      wb_res_mux          <= ex_res_mux;
      wb_reg_dst          <= ex_reg_dst;
      wb_alu_out          <= ex_alu_out;
      wb_mem_rdata        <= 32'd0;
      wb_next_pc          <= ex_next_pc;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, stores,
// flags/branches, access timeout and asynchronous reset during an access.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int PC_WIDTH = 32;

  logic        clk, rst;
  logic        in_valid, in_mem_write_enable, in_fl_write_enable, in_sel_jt_jf;
  logic        in_is_branch, in_is_jump, in_reg_write_enable;
  logic [1:0]  in_wb_res_mux;
  logic [PC_WIDTH-1:0] in_next_pc;
  logic [31:0] in_abs_addr, in_mem_addr, in_mem_data, in_alu_out;
  logic [5:0]  in_alu_flags;
  logic [4:0]  in_flag_addr, in_reg_dst;
  logic        stall, branch_taken, dmem_req, dmem_we, dmem_ack, mem_error;
  logic [31:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata;
  logic [5:0]  flags;
  logic        wb_valid, wb_reg_write_enable;
  logic [1:0]  wb_res_mux;
  logic [4:0]  wb_reg_dst;
  logic [31:0] wb_alu_out, wb_mem_rdata;
  logic [PC_WIDTH-1:0] wb_next_pc;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage #(.PC_WIDTH(PC_WIDTH), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_write_enable(in_mem_write_enable),
    .in_fl_write_enable(in_fl_write_enable), .in_sel_jt_jf(in_sel_jt_jf),
    .in_is_branch(in_is_branch), .in_is_jump(in_is_jump), .in_wb_res_mux(in_wb_res_mux),
    .in_reg_write_enable(in_reg_write_enable), .in_next_pc(in_next_pc),
    .in_abs_addr(in_abs_addr), .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data),
    .in_alu_out(in_alu_out), .in_alu_flags(in_alu_flags), .in_flag_addr(in_flag_addr),
    .in_reg_dst(in_reg_dst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_error(mem_error), .flags(flags), .wb_valid(wb_valid),
    .wb_reg_write_enable(wb_reg_write_enable), .wb_res_mux(wb_res_mux),
    .wb_reg_dst(wb_reg_dst), .wb_alu_out(wb_alu_out), .wb_mem_rdata(wb_mem_rdata),
    .wb_next_pc(wb_next_pc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; in_mem_write_enable = 0; in_fl_write_enable = 0; in_sel_jt_jf = 0;
    in_is_branch = 0; in_is_jump = 0; in_reg_write_enable = 0; in_wb_res_mux = WB_ALU;
    in_next_pc = '0; in_abs_addr = '0; in_mem_addr = '0; in_mem_data = '0;
    in_alu_out = '0; in_alu_flags = '0; in_flag_addr = '0; in_reg_dst = '0;
  endtask

  task automatic drive_alu(input logic [31:0] res, input logic [4:0] dst,
                           input logic fl_we, input logic [5:0] fl);
    set_idle();
    in_valid = 1; in_reg_write_enable = 1; in_wb_res_mux = WB_ALU;
    in_alu_out = res; in_reg_dst = dst; in_fl_write_enable = fl_we; in_alu_flags = fl;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] dst);
    set_idle();
    in_valid = 1; in_reg_write_enable = 1; in_wb_res_mux = WB_MEM;
    in_mem_addr = addr; in_reg_dst = dst;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
    set_idle();
    in_valid = 1; in_mem_write_enable = 1; in_mem_addr = addr; in_mem_data = data;
  endtask

  task automatic drive_branch(input logic [4:0] fa, input logic sel, input logic [31:0] tgt);
    set_idle();
    in_valid = 1; in_is_branch = 1; in_flag_addr = fa; in_sel_jt_jf = sel; in_abs_addr = tgt;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1; set_idle(); dmem_ack = 0; dmem_rdata = '0;
    tick(); tick();
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset stall got %0b exp 0", stall); end
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset dmem_req got %0b exp 0", dmem_req); end
    tests_run++; if (dmem_we !== 1'b0) begin tests_failed++; $display("FAIL reset dmem_we got %0b exp 0", dmem_we); end
    tests_run++; if (flags !== 6'd0) begin tests_failed++; $display("FAIL reset flags got %b exp 0", flags); end
    tests_run++; if (mem_error !== 1'b0) begin tests_failed++; $display("FAIL reset mem_error got %0b exp 0", mem_error); end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset wb_valid got %0b exp 0", wb_valid); end
    tests_run++; if (wb_reg_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset wb_rwe got %0b exp 0", wb_reg_write_enable); end
    tests_run++; if (wb_alu_out !== 32'd0) begin tests_failed++; $display("FAIL reset wb_alu_out got %h exp 0", wb_alu_out); end
    tests_run++; if (wb_mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset wb_mem_rdata got %h exp 0", wb_mem_rdata); end
    tests_run++; if (wb_next_pc !== '0) begin tests_failed++; $display("FAIL reset wb_next_pc got %h exp 0", wb_next_pc); end
    tests_run++; if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL reset branch_taken got %0b exp 0", branch_taken); end
    rst = 0;
    tick();
  endtask

  task automatic test_alu();
    drive_alu(32'h1234, 5'd5, 0, 6'd0);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu stall_pre got %0b exp 0", stall); end
    tick(); set_idle();
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu stall_ex got %0b exp 0", stall); end
    tick();
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL alu wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (wb_alu_out !== 32'h1234) begin tests_failed++; $display("FAIL alu wb_alu_out got %h exp 1234", wb_alu_out); end
    tests_run++; if (wb_reg_dst !== 5'd5) begin tests_failed++; $display("FAIL alu wb_reg_dst got %0d exp 5", wb_reg_dst); end
    tests_run++; if (wb_mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL alu wb_mem_rdata got %h exp 0", wb_mem_rdata); end
    tick();
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL alu wb_valid_after got %0b exp 0", wb_valid); end
  endtask

  task automatic test_load();
    drive_load(32'h40, 5'd3);
    tick(); set_idle();
    for (int k = 1; k <= 3; k++) begin
      dmem_ack = (k == 3);
      dmem_rdata = (k == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      tests_run++; if (dmem_req !== 1'b1) begin tests_failed++; $display("FAIL load dmem_req c%0d got %0b exp 1", k, dmem_req); end
      tests_run++; if (dmem_we !== 1'b0) begin tests_failed++; $display("FAIL load dmem_we c%0d got %0b exp 0", k, dmem_we); end
      tests_run++; if (dmem_addr !== 32'h40) begin tests_failed++; $display("FAIL load dmem_addr c%0d got %h exp 40", k, dmem_addr); end
      tests_run++; if (stall !== (k < 3)) begin tests_failed++; $display("FAIL load stall c%0d got %0b exp %0b", k, stall, (k < 3)); end
      tick();
    end
    dmem_ack = 0; dmem_rdata = 32'h0;
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL load wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (wb_mem_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load wb_mem_rdata got %h exp deadbeef", wb_mem_rdata); end
    tests_run++; if (wb_reg_dst !== 5'd3) begin tests_failed++; $display("FAIL load wb_reg_dst got %0d exp 3", wb_reg_dst); end
    tests_run++; if (wb_reg_write_enable !== 1'b1) begin tests_failed++; $display("FAIL load wb_rwe got %0b exp 1", wb_reg_write_enable); end
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL load dmem_req_after got %0b exp 0", dmem_req); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_store(32'h80, 32'hA5A5A5A5);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL store stall_pre got %0b exp 0", stall); end
    tick();
    drive_alu(32'h77, 5'd7, 0, 6'd0);
    dmem_ack = 1; #1;
    tests_run++; if (dmem_req !== 1'b1) begin tests_failed++; $display("FAIL store dmem_req got %0b exp 1", dmem_req); end
    tests_run++; if (dmem_we !== 1'b1) begin tests_failed++; $display("FAIL store dmem_we got %0b exp 1", dmem_we); end
    tests_run++; if (dmem_addr !== 32'h80) begin tests_failed++; $display("FAIL store dmem_addr got %h exp 80", dmem_addr); end
    tests_run++; if (dmem_wdata !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL store dmem_wdata got %h exp a5a5a5a5", dmem_wdata); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL store stall got %0b exp 0", stall); end
    tick();
    set_idle(); dmem_ack = 0;
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL store wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (wb_mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL store wb_mem_rdata got %h exp 0", wb_mem_rdata); end
    tests_run++; if (wb_reg_write_enable !== 1'b0) begin tests_failed++; $display("FAIL store wb_rwe got %0b exp 0", wb_reg_write_enable); end
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL store dmem_req_after got %0b exp 0", dmem_req); end
    tick();
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (wb_alu_out !== 32'h77) begin tests_failed++; $display("FAIL b2b wb_alu_out got %h exp 77", wb_alu_out); end
    tests_run++; if (wb_reg_dst !== 5'd7) begin tests_failed++; $display("FAIL b2b wb_reg_dst got %0d exp 7", wb_reg_dst); end
    tick();
  endtask

  task automatic test_flags_branch();
    drive_alu(32'h0, 5'd1, 1, 6'b000001);
    tick();
    drive_branch(5'd0, 1'b1, 32'h100);
    tests_run++; if (flags !== 6'b000001) begin tests_failed++; $display("FAIL flags got %b exp 000001", flags); end
    tick();
    drive_alu(32'hBAD, 5'd9, 0, 6'd0);
    #1;
    tests_run++; if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL branch taken got %0b exp 1", branch_taken); end
    tests_run++; if (branch_target !== 32'h100) begin tests_failed++; $display("FAIL branch target got %h exp 100", branch_target); end
    tick();
    set_idle();
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL branch wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL branch squashed_taken got %0b exp 0", branch_taken); end
    tick();
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL branch squash wb_valid got %0b exp 0", wb_valid); end
  endtask

  task automatic test_branch_boundary();
    drive_branch(5'd6, 1'b1, 32'h300);
    tick();
    tests_run++; if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL flag6 taken got %0b exp 0", branch_taken); end
    drive_branch(5'd7, 1'b0, 32'h304);
    tick();
    tests_run++; if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL flag7 taken got %0b exp 1", branch_taken); end
    tests_run++; if (branch_target !== 32'h304) begin tests_failed++; $display("FAIL flag7 target got %h exp 304", branch_target); end
    set_idle(); tick();
    set_idle();
    in_valid = 1; in_is_jump = 1; in_abs_addr = 32'h200; in_wb_res_mux = WB_PC;
    in_reg_write_enable = 1; in_next_pc = 32'h44; in_reg_dst = 5'd31;
    tick(); set_idle();
    tests_run++; if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL jump taken got %0b exp 1", branch_taken); end
    tests_run++; if (branch_target !== 32'h200) begin tests_failed++; $display("FAIL jump target got %h exp 200", branch_target); end
    tick();
    tests_run++; if (wb_next_pc !== 32'h44) begin tests_failed++; $display("FAIL jump wb_next_pc got %h exp 44", wb_next_pc); end
    tests_run++; if (wb_res_mux !== WB_PC) begin tests_failed++; $display("FAIL jump wb_res_mux got %0d exp 2", wb_res_mux); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic seen_err;
    n = 0; seen_err = 0;
    drive_load(32'h44, 5'd4);
    tick(); set_idle();
    while (stall && n < 40) begin
      if (mem_error) seen_err = 1;
      n++;
      tick();
    end
    tests_run++; if (n !== 15) begin tests_failed++; $display("FAIL timeout stall_cycles got %0d exp 15", n); end
    tests_run++; if (seen_err !== 1'b0) begin tests_failed++; $display("FAIL timeout early_error got %0b exp 0", seen_err); end
    tests_run++; if (dmem_req !== 1'b1) begin tests_failed++; $display("FAIL timeout last_req got %0b exp 1", dmem_req); end
    tests_run++; if (mem_error !== 1'b0) begin tests_failed++; $display("FAIL timeout err_pre got %0b exp 0", mem_error); end
    tick();
    tests_run++; if (mem_error !== 1'b1) begin tests_failed++; $display("FAIL timeout mem_error got %0b exp 1", mem_error); end
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL timeout wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (wb_reg_write_enable !== 1'b0) begin tests_failed++; $display("FAIL timeout wb_rwe got %0b exp 0", wb_reg_write_enable); end
    tests_run++; if (wb_mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL timeout wb_mem_rdata got %h exp 0", wb_mem_rdata); end
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL timeout req_after got %0b exp 0", dmem_req); end
    tick();
    tests_run++; if (mem_error !== 1'b0) begin tests_failed++; $display("FAIL timeout err_pulse got %0b exp 0", mem_error); end
  endtask

  task automatic test_reset_mid_access();
    drive_alu(32'h0, 5'd0, 1, 6'b101010);
    tick();
    drive_load(32'h48, 5'd6);
    tick(); set_idle();
    tick();
    tests_run++; if (dmem_req !== 1'b1) begin tests_failed++; $display("FAIL rstmid req_pre got %0b exp 1", dmem_req); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL rstmid stall_pre got %0b exp 1", stall); end
    tests_run++; if (flags !== 6'b101010) begin tests_failed++; $display("FAIL rstmid flags_pre got %b exp 101010", flags); end
    #2 rst = 1;
    #1;
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid dmem_req got %0b exp 0", dmem_req); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rstmid stall got %0b exp 0", stall); end
    tests_run++; if (flags !== 6'd0) begin tests_failed++; $display("FAIL rstmid flags got %b exp 0", flags); end
    tick();
    rst = 0;
    drive_alu(32'h55, 5'd2, 0, 6'd0);
    tick(); set_idle();
    tick();
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid wb_valid got %0b exp 1", wb_valid); end
    tests_run++; if (wb_alu_out !== 32'h55) begin tests_failed++; $display("FAIL rstmid wb_alu_out got %h exp 55", wb_alu_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_flags_branch();
    test_branch_boundary();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
